branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-side branch predictor. It is the consumer of execute-stage branch resolution and the producer of the per-instruction prediction bit that execute later checks.
- Gives a same-cycle prediction for the fetch PC: direction from a gshare BHT of 2-bit counters, target from a direct-mapped BTB.
- Trains from execute's resolution outputs through a one-cycle registered update stage.
- On reset, a sequential init FSM clears the tables, so no wide reset fan-out is needed.

Parameters:
- XLEN, 32, data width
- PC_WIDTH, 32, PC width
- IDX_W, 6, log2 of table entries (ENTRIES = 2**IDX_W); applies to both BHT and BTB
- GHR_LEN, 6, global history length; 0 gives a bimodal predictor; must be <= IDX_W

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- F_PC_i  in  PC_WIDTH  current fetch PC
- F_predict_taken_o  out  1  predicted taken; carried down the pipe as the instruction's predict bit
- F_predict_target_o  out  PC_WIDTH  predicted next PC
- F_btb_hit_o  out  1  BTB tag hit for F_PC_i
- E_update_valid_i  in  1  a conditional branch resolved in execute this cycle
- E_PC_i  in  PC_WIDTH  PC of the resolved branch
- E_predict_i  in  1  predict bit that travelled with that branch
- E_train_correct_i  in  1  1 = prediction was correct (execute's XNOR of outcome and prediction)
- E_target_i  in  PC_WIDTH  taken target (PC + imm)
- P_ready_o  out  1  initialisation complete
- P_branch_cnt_o  out  32  resolved-branch count
- P_mispredict_cnt_o  out  32  mispredict count

Behaviour:
- Reset: clk and rst only; reset is synchronous and active-high.
  - On reset: state=INIT, init_idx=0, GHR=0, pending-update valid=0, both counters=0.
  - Output reset values: P_ready_o=0, F_predict_taken_o=0, F_btb_hit_o=0, F_predict_target_o=F_PC_i+4.
- FSM INIT:
  - Each cycle writes BHT[init_idx]=2'b01 (weakly not-taken) and BTB_valid[init_idx]=0, then increments init_idx.
  - After the write at init_idx=ENTRIES-1, go to RUN. INIT lasts exactly ENTRIES cycles.
  - During INIT: updates are ignored (not counted, GHR unchanged); prediction is not-taken with target PC+4.
- FSM RUN: P_ready_o=1 and the block stays in RUN until rst. Asserting rst in any state returns to INIT and discards any pending update.
- Indexing:
  - btb_idx = PC[IDX_W+1:2].
  - tag = PC[PC_WIDTH-1:IDX_W+2].
  - bht_idx = btb_idx XOR zero-extended GHR[GHR_LEN-1:0].
- Predict path (combinational, zero latency):
  - hit = BTB_valid & tag match.
  - taken = hit & BHT[bht_idx][1].
  - target = taken ? BTB_target : F_PC_i+4, with 32-bit wrap.
- Actual outcome: actual = ~(E_train_correct_i ^ E_predict_i).
- Update capture, cycle N (RUN and E_update_valid_i):
  - Latch the bht_idx computed with the current GHR, btb_idx, tag, actual, and target into the pending register.
  - GHR <= {GHR[GHR_LEN-2:0], actual}, visible in cycle N+1.
  - branch_cnt +1; mispredict_cnt +1 if E_train_correct_i=0. Both counters wrap at 2^32.
- Update write, cycle N+1:
  - BHT counter saturating: actual ? min(c+1,3) : max(c-1,0).
  - If actual=1, the BTB entry is overwritten: valid=1, tag, target.
  - If actual=0, the BTB is left untouched.
- Forwarding: while a write is pending, a fetch read of the same bht_idx or btb_idx returns the post-write value. This makes back-to-back updates and predictions of the same branch coherent.
- Simultaneous capture in cycle N+1 and write of the cycle-N update: both proceed. If the new capture hits the same bht_idx, its counter base comes from the pending result, not the stale array.
- Last RUN cycle before rst: any capture is lost.

Decomposition:
- Shared package: IDX_W and GHR_LEN defaults, the counter encodings (SNT=00, WNT=01, WT=10, ST=11), and the FSM state encoding.
- One natural sub-module, sat_counter2: 2-bit saturating increment/decrement, combinational, reused in the write and forward paths.

Test Plan:
- Reset, then hold F_PC_i=0x100 -> P_ready_o=0 for exactly 64 cycles and rises in cycle 64; predict not-taken with target 0x104 throughout.
- GHR_LEN=0. Branch at 0x200 resolves taken to 0x180 twice (E_predict_i=0, correct=0) -> mispredict_cnt=2; then F_PC_i=0x200 gives hit=1, taken=1, target=0x180.
- Saturation: four more taken updates at 0x200, then one not-taken -> counter goes 3 then 2, prediction stays taken; a second not-taken -> counter 1, predicted not-taken.
- Forwarding: update at 0x300 (taken to 0x400) in cycle N with F_PC_i=0x300 in cycle N+1 -> hit=1, target=0x400 in N+1.
- Alias: 0x200 and 0x200+(64<<2) -> the tag mismatch gives hit=0 until the second branch is allocated, which evicts the first.
- Reset mid-RUN with a pending update -> the pending write does not land; after INIT, 0x200 misses and both counters read 0.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-side gshare branch predictor:
// table sizing defaults, 2-bit counter encodings and init/run FSM states.
package branch_predictor_pkg;

   localparam int IDX_W_DEF   = 6;
   localparam int GHR_LEN_DEF = 6;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } cnt_e;

   typedef enum logic {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch prediction, execute resolution and status signals of the branch predictor.
// The predictor is the slave; the pipeline (or bench) driving fetch/execute is the master.
interface branch_predictor_if #(
   parameter int PC_WIDTH = 32,
   parameter int XLEN     = 32
);
   logic [PC_WIDTH-1:0] F_PC_i;
   logic                F_predict_taken_o;
   logic [PC_WIDTH-1:0] F_predict_target_o;
   logic                F_btb_hit_o;
   logic                E_update_valid_i;
   logic [PC_WIDTH-1:0] E_PC_i;
   logic                E_predict_i;
   logic                E_train_correct_i;
   logic [PC_WIDTH-1:0] E_target_i;
   logic                P_ready_o;
   logic [XLEN-1:0]     P_branch_cnt_o;
   logic [XLEN-1:0]     P_mispredict_cnt_o;

   modport master (
      output F_PC_i, E_update_valid_i, E_PC_i, E_predict_i, E_train_correct_i, E_target_i,
      input  F_predict_taken_o, F_predict_target_o, F_btb_hit_o,
      input  P_ready_o, P_branch_cnt_o, P_mispredict_cnt_o
   );

   modport slave (
      input  F_PC_i, E_update_valid_i, E_PC_i, E_predict_i, E_train_correct_i, E_target_i,
      output F_predict_taken_o, F_predict_target_o, F_btb_hit_o,
      output P_ready_o, P_branch_cnt_o, P_mispredict_cnt_o
   );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating counter step: increments toward ST when inc, else decrements toward SNT.
module sat_counter2
   import branch_predictor_pkg::*;
(
   input  logic [1:0] cnt,
   input  logic       inc,
   output logic [1:0] nxt
);
   always_comb begin
      nxt = cnt;
      if (inc) begin
         if (cnt != ST) nxt = cnt + 2'd1;
      end else begin
         if (cnt != SNT) nxt = cnt - 2'd1;
      end
   end
endmodule

// File: rtl/branch_predictor.sv
// Gshare direction predictor plus direct-mapped BTB with a one-cycle registered
// update stage; tables are cleared by a sequential init walk after reset.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int PC_WIDTH = 32,
   parameter int IDX_W    = IDX_W_DEF,
   parameter int GHR_LEN  = GHR_LEN_DEF
) (
   input logic               clk,
   input logic               rst,
   branch_predictor_if.slave bp
);
   localparam int ENTRIES = 2 ** IDX_W;
   localparam int WORD_W  = PC_WIDTH - 2;
   localparam int TAG_W   = PC_WIDTH - IDX_W - 2;

   state_e           state;
   logic [IDX_W-1:0] init_idx;
   logic             ready;
   logic             run;

   logic [1:0]          bht        [ENTRIES];
   logic                btb_valid  [ENTRIES];
   logic [TAG_W-1:0]    btb_tag    [ENTRIES];
   logic [PC_WIDTH-1:0] btb_target [ENTRIES];

   logic [IDX_W-1:0] ghr_ext;

   logic [WORD_W-1:0] e_word_p0;
   logic [IDX_W-1:0]  btb_idx_p0, bht_idx_p0;
   logic [TAG_W-1:0]  tag_p0;
   logic              cap_p0, actual_p0;
   logic [1:0]        base_p0, cnt_nxt_p0;

   logic                vld_p1, actual_p1;
   logic [IDX_W-1:0]    btb_idx_p1, bht_idx_p1;
   logic [TAG_W-1:0]    tag_p1;
   logic [PC_WIDTH-1:0] target_p1;
   logic [1:0]          cnt_p1;

   logic [XLEN-1:0] branch_cnt, mispredict_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_INIT;
         init_idx <= '0;
         ready    <= 1'b0;
      end else if (state == S_INIT) begin
         init_idx <= init_idx + IDX_W'(1);
         if (init_idx == IDX_W'(ENTRIES - 1)) begin
            state <= S_RUN;
            ready <= 1'b1;
         end
      end
   end

   assign run          = (state == S_RUN);
   assign bp.P_ready_o = ready;

   generate
      if (GHR_LEN > 0) begin : g_ghr
         logic [GHR_LEN-1:0] ghr;
         always_ff @(posedge clk) begin
            if (rst)         ghr <= '0;
            else if (cap_p0) ghr <= GHR_LEN'({ghr, actual_p0});
         end
         assign ghr_ext = IDX_W'(ghr);
      end else begin : g_bimodal
         assign ghr_ext = '0;
      end
   endgenerate

   // p0: capture resolution; the counter base forwards from a pending write to the same entry
   assign cap_p0     = run && bp.E_update_valid_i;
   assign actual_p0  = ~(bp.E_train_correct_i ^ bp.E_predict_i);
   assign e_word_p0  = WORD_W'(bp.E_PC_i >> 2);
   assign btb_idx_p0 = e_word_p0[IDX_W-1:0];
   assign tag_p0     = e_word_p0[WORD_W-1:IDX_W];
   assign bht_idx_p0 = btb_idx_p0 ^ ghr_ext;
   assign base_p0    = (vld_p1 && bht_idx_p1 == bht_idx_p0) ? cnt_p1 : bht[bht_idx_p0];

   sat_counter2 u_sat (
      .cnt (base_p0),
      .inc (actual_p0),
      .nxt (cnt_nxt_p0)
   );

   // p1: pending write register; a capture in the cycle rst is high never becomes pending
   always_ff @(posedge clk) begin
      if (rst) vld_p1 <= 1'b0;
      else     vld_p1 <= cap_p0;
   end

   always_ff @(posedge clk) begin
      if (cap_p0) begin
         btb_idx_p1 <= btb_idx_p0;
         bht_idx_p1 <= bht_idx_p0;
         tag_p1     <= tag_p0;
         actual_p1  <= actual_p0;
         target_p1  <= bp.E_target_i;
         cnt_p1     <= cnt_nxt_p0;
      end
   end

   always_ff @(posedge clk) begin
      if (state == S_INIT) begin
         bht[init_idx]       <= WNT;
         btb_valid[init_idx] <= 1'b0;
      end else if (vld_p1 && !rst) begin
         bht[bht_idx_p1] <= cnt_p1;
         if (actual_p1) begin
            btb_valid[btb_idx_p1]  <= 1'b1;
            btb_tag[btb_idx_p1]    <= tag_p1;
            btb_target[btb_idx_p1] <= target_p1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         branch_cnt     <= '0;
         mispredict_cnt <= '0;
      end else if (cap_p0) begin
         branch_cnt <= branch_cnt + XLEN'(1);
         if (!bp.E_train_correct_i) mispredict_cnt <= mispredict_cnt + XLEN'(1);
      end
   end

   assign bp.P_branch_cnt_o     = branch_cnt;
   assign bp.P_mispredict_cnt_o = mispredict_cnt;

   logic [WORD_W-1:0]   f_word;
   logic [IDX_W-1:0]    f_btb_idx, f_bht_idx;
   logic [TAG_W-1:0]    f_tag, f_tag_q;
   logic [1:0]          f_cnt;
   logic                f_valid, f_hit, f_taken;
   logic [PC_WIDTH-1:0] f_target;

   assign f_word    = WORD_W'(bp.F_PC_i >> 2);
   assign f_btb_idx = f_word[IDX_W-1:0];
   assign f_tag     = f_word[WORD_W-1:IDX_W];
   assign f_bht_idx = f_btb_idx ^ ghr_ext;

   // Fetch sees the pending write as if it had already landed
   always_comb begin
      f_cnt    = bht[f_bht_idx];
      f_valid  = btb_valid[f_btb_idx];
      f_tag_q  = btb_tag[f_btb_idx];
      f_target = btb_target[f_btb_idx];
      if (vld_p1 && bht_idx_p1 == f_bht_idx) f_cnt = cnt_p1;
      if (vld_p1 && actual_p1 && btb_idx_p1 == f_btb_idx) begin
         f_valid  = 1'b1;
         f_tag_q  = tag_p1;
         f_target = target_p1;
      end
   end

   assign f_hit   = run && f_valid && (f_tag_q == f_tag);
   assign f_taken = f_hit && (f_cnt >= WT);

   assign bp.F_btb_hit_o        = f_hit;
   assign bp.F_predict_taken_o  = f_taken;
   assign bp.F_predict_target_o = f_taken ? f_target : bp.F_PC_i + PC_WIDTH'(4);
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor in bimodal mode (GHR_LEN=0): init walk,
// training, saturation, forwarding, tag aliasing and reset with a pending update.
module tb_branch_predictor;
   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   branch_predictor_if #(.PC_WIDTH(32), .XLEN(32)) bif ();

   branch_predictor #(
      .XLEN     (32),
      .PC_WIDTH (32),
      .IDX_W    (6),
      .GHR_LEN  (0)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bp  (bif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pred_chk(input string tag, input logic [31:0] pc, input logic hit,
                           input logic taken, input logic [31:0] tgt);
      bif.F_PC_i = pc;
      #1;
      chk({tag, "_hit"}, 32'(bif.F_btb_hit_o), 32'(hit));
      chk({tag, "_taken"}, 32'(bif.F_predict_taken_o), 32'(taken));
      chk({tag, "_target"}, bif.F_predict_target_o, tgt);
   endtask

   task automatic cnt_chk(input string tag, input logic [31:0] br, input logic [31:0] mp);
      chk({tag, "_branch_cnt"}, bif.P_branch_cnt_o, br);
      chk({tag, "_mispredict_cnt"}, bif.P_mispredict_cnt_o, mp);
   endtask

   task automatic upd(input logic [31:0] pc, input logic pred, input logic corr,
                      input logic [31:0] tgt);
      bif.E_update_valid_i  = 1'b1;
      bif.E_PC_i            = pc;
      bif.E_predict_i       = pred;
      bif.E_train_correct_i = corr;
      bif.E_target_i        = tgt;
      @(negedge clk);
   endtask

   task automatic idle();
      bif.E_update_valid_i = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int n;
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      bif.F_PC_i            = 32'h100;
      bif.E_update_valid_i  = 1'b0;
      bif.E_PC_i            = 32'h0;
      bif.E_predict_i       = 1'b0;
      bif.E_train_correct_i = 1'b0;
      bif.E_target_i        = 32'h0;
      repeat (3) @(negedge clk);

      chk("rst_ready", 32'(bif.P_ready_o), 32'd0);
      pred_chk("rst", 32'h100, 1'b0, 1'b0, 32'h104);
      cnt_chk("rst", 32'd0, 32'd0);

      // Init walk: ready low for exactly 64 cycles; updates offered meanwhile are ignored
      rst = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (i == 10) begin
            bif.E_update_valid_i  = 1'b1;
            bif.E_PC_i            = 32'h200;
            bif.E_train_correct_i = 1'b0;
            bif.E_target_i        = 32'h180;
         end
         if (i == 13) bif.E_update_valid_i = 1'b0;
         #1;
         chk("init_ready", 32'(bif.P_ready_o), 32'd0);
         chk("init_taken", 32'(bif.F_predict_taken_o), 32'd0);
         chk("init_target", bif.F_predict_target_o, 32'h104);
         @(negedge clk);
      end
      chk("run_ready", 32'(bif.P_ready_o), 32'd1);
      pred_chk("empty", 32'h100, 1'b0, 1'b0, 32'h104);
      cnt_chk("init_ignored", 32'd0, 32'd0);

      // Two back-to-back taken mispredicts at 0x200: WNT -> WT -> ST
      upd(32'h200, 1'b0, 1'b0, 32'h180);
      upd(32'h200, 1'b0, 1'b0, 32'h180);
      cnt_chk("train", 32'd2, 32'd2);
      idle();
      pred_chk("trained", 32'h200, 1'b1, 1'b1, 32'h180);

      // Saturate at ST, then step down: ST -> WT (still taken) -> WNT (not taken)
      repeat (4) upd(32'h200, 1'b1, 1'b1, 32'h180);
      upd(32'h200, 1'b1, 1'b0, 32'h180);
      idle();
      cnt_chk("sat_dn1", 32'd7, 32'd3);
      pred_chk("sat_dn1", 32'h200, 1'b1, 1'b1, 32'h180);
      upd(32'h200, 1'b1, 1'b0, 32'h180);
      idle();
      cnt_chk("sat_dn2", 32'd8, 32'd4);
      pred_chk("sat_dn2", 32'h200, 1'b1, 1'b0, 32'h204);

      // 0x300 aliases 0x200 in the BTB: miss, then forwarded allocation, then eviction
      pred_chk("alias_miss", 32'h300, 1'b0, 1'b0, 32'h304);
      upd(32'h300, 1'b0, 1'b0, 32'h400);
      bif.E_update_valid_i = 1'b0;
      pred_chk("fwd", 32'h300, 1'b1, 1'b1, 32'h400);
      idle();
      pred_chk("evicted", 32'h200, 1'b0, 1'b0, 32'h204);
      cnt_chk("alias", 32'd9, 32'd5);

      // Reset while an update is pending: the write is dropped and counters clear
      upd(32'h200, 1'b0, 1'b0, 32'h180);
      bif.E_update_valid_i = 1'b0;
      cnt_chk("pre_rst", 32'd10, 32'd6);
      pred_chk("pre_rst_fwd", 32'h200, 1'b1, 1'b1, 32'h180);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_ready", 32'(bif.P_ready_o), 32'd0);
      cnt_chk("mid_rst", 32'd0, 32'd0);
      pred_chk("mid_rst", 32'h200, 1'b0, 1'b0, 32'h204);
      rst = 1'b0;
      n = 0;
      while (!bif.P_ready_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("reinit_cycles", 32'(n), 32'd64);
      pred_chk("post_rst", 32'h200, 1'b0, 1'b0, 32'h204);
      cnt_chk("post_rst", 32'd0, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
